fp16_posit_serial_enc: RTL and testbench

Converts an FP16 value into a posit(N,0) word, with N runtime-selectable from 2 to 8 and es=0. It then streams that word out one bit per cycle, MSB first. This is the weight-side transmitter for the team's bit-serial posit multipliers: it feeds the serial w-bit stream and frame-valid those multipliers consume. Encoding is round-to-nearest-even with posit saturation.

---
 rtl/posit_enc_pkg.sv | 49 ++++
 rtl/fp16_to_posit_comb.sv | 74 +++++++
 rtl/fp16_posit_serial_enc.sv | 91 +++++++++
 tb/tb_fp16_posit_serial_enc.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/posit_enc_pkg.sv
// Shared constants, FSM state type and word-construction helpers for the
// FP16 to posit(N,0) serial weight transmitter.
package posit_enc_pkg;

  localparam int unsigned FP_WIDTH    = 16;
  localparam int unsigned EXP_W       = 5;
  localparam int unsigned MAN_W       = 10;
  localparam int unsigned FP_BIAS     = 15;
  localparam int unsigned EXP_SPECIAL = 31;

  localparam int unsigned MAX_N      = 8;
  localparam int unsigned MIN_N      = 2;
  localparam int unsigned RESET_N    = 4;
  localparam int unsigned NPOS_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENC   = 2'd1,
    SHIFT = 2'd2
  } enc_state_e;

  localparam logic [MAX_N-1:0] ZERO_WORD = '0;
  localparam logic [MAX_N-1:0] MINPOS_MAG = MAX_N'(1);

  // Precision requests outside 2..MAX_N snap to the nearest legal width.
  function automatic logic [NPOS_W-1:0] clamp_npos(input logic [NPOS_W-1:0] p);
    if (p < NPOS_W'(MIN_N)) return NPOS_W'(MIN_N);
    if (p > NPOS_W'(MAX_N)) return NPOS_W'(MAX_N);
    return p;
  endfunction

  // NaR: sign bit of an n-bit word set, everything else clear.
  function automatic logic [MAX_N-1:0] nar_word(input logic [NPOS_W-1:0] n);
    return MAX_N'(1) << (n - NPOS_W'(1));
  endfunction

  // Low n bits set; computed one bit wider so n == MAX_N does not wrap.
  function automatic logic [MAX_N-1:0] word_mask(input logic [NPOS_W-1:0] n);
    logic [MAX_N:0] tmp;
    tmp = ((MAX_N+1)'(1) << n) - (MAX_N+1)'(1);
    return tmp[MAX_N-1:0];
  endfunction

  // Largest magnitude field of m bits: all ones.
  function automatic logic [MAX_N-1:0] maxpos_mag(input logic [NPOS_W-1:0] m);
    return (MAX_N'(1) << m) - MAX_N'(1);
  endfunction

endpackage

// File: rtl/fp16_to_posit_comb.sv
// Combinational FP16 -> posit(npos,0) encoder, round-to-nearest-even with
// posit saturation; result right-aligned in MAX_N bits.
module fp16_to_posit_comb
  import posit_enc_pkg::*;
(
  input  logic [FP_WIDTH-1:0] act,
  input  logic [NPOS_W-1:0]   npos,
  output logic [MAX_N-1:0]    word
);

  localparam int unsigned STR_W = 32;

  logic                 sign;
  logic [EXP_W-1:0]     exp_f;
  logic [MAN_W-1:0]     man;
  logic signed [6:0]    k;
  logic                 k_neg;
  logic [4:0]           k_abs;
  logic [5:0]           rlen;
  logic [STR_W-1:0]     regime;
  logic [STR_W-1:0]     str;
  logic [NPOS_W-1:0]    m;
  logic [4:0]           gidx;
  logic [MAX_N-1:0]     top;
  logic [MAX_N-1:0]     mag;
  logic [MAX_N-1:0]     maxp;
  logic [MAX_N-1:0]     mask;
  logic                 guard;
  logic                 sticky;
  logic                 rnd;

  always_comb begin
    sign   = act[FP_WIDTH-1];
    exp_f  = act[MAN_W +: EXP_W];
    man    = act[MAN_W-1:0];
    m      = npos - NPOS_W'(1);
    mask   = word_mask(npos);
    maxp   = maxpos_mag(m);

    k      = $signed({2'b00, exp_f}) - 7'sd15;
    k_neg  = k[6];
    k_abs  = k_neg ? 5'(-k) : 5'(k);

    // Regime left-aligned in a wide string, fraction packed right after it.
    if (k_neg) begin
      regime = {1'b1, {(STR_W-1){1'b0}}} >> k_abs;
      rlen   = 6'(k_abs) + 6'd1;
    end else begin
      regime = ~({STR_W{1'b1}} >> (k_abs + 5'd1));
      rlen   = 6'(k_abs) + 6'd2;
    end
    str    = regime | ({man, {(STR_W-MAN_W){1'b0}}} >> rlen);

    top    = MAX_N'(str[STR_W-1 -: MAX_N-1] >> (NPOS_W'(MAX_N-1) - m));
    gidx   = 5'(STR_W-1) - 5'(m);
    guard  = str[gidx];
    sticky = |(str << (m + NPOS_W'(1)));
    rnd    = guard & (sticky | top[0]);

    mag    = top + MAX_N'(rnd);
    if (mag > maxp)       mag = maxp;
    if (mag == ZERO_WORD) mag = MINPOS_MAG;

    if (exp_f == EXP_W'(EXP_SPECIAL)) begin
      word = nar_word(npos);
    end else if (exp_f == '0 && man == '0) begin
      word = ZERO_WORD;
    end else begin
      if (exp_f == '0) mag = MINPOS_MAG;
      word = sign ? ((~mag + MAX_N'(1)) & mask) : mag;
    end
  end

endmodule

// File: rtl/fp16_posit_serial_enc.sv
// Bit-serial posit weight transmitter: latches an FP16 operand, encodes it
// to posit(npos,0) and streams the word MSB first under out_ready control.
module fp16_posit_serial_enc
  import posit_enc_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set,
  input  logic [NPOS_W-1:0]   precision,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [FP_WIDTH-1:0] act,
  input  logic                out_ready,
  output logic                w_valid,
  output logic                w_bit,
  output logic                w_last,
  output logic [MAX_N-1:0]    posit_out,
  output logic                done
);

  enc_state_e          state;
  logic [NPOS_W-1:0]   npos_q;
  logic [FP_WIDTH-1:0] act_q;
  logic [NPOS_W-1:0]   cnt;
  logic [MAX_N-1:0]    enc_word;
  logic [2:0]          first_idx;
  logic [2:0]          next_idx;

  fp16_to_posit_comb u_enc (
    .act  (act_q),
    .npos (npos_q),
    .word (enc_word)
  );

  assign first_idx = 3'(npos_q - NPOS_W'(1));
  assign next_idx  = 3'(npos_q - NPOS_W'(2) - cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      npos_q    <= NPOS_W'(RESET_N);
      act_q     <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      w_valid   <= 1'b0;
      w_bit     <= 1'b0;
      w_last    <= 1'b0;
      posit_out <= '0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (set) npos_q <= clamp_npos(precision);
          if (in_valid) begin
            act_q    <= act;
            in_ready <= 1'b0;
            state    <= ENC;
          end
        end
        ENC: begin
          posit_out <= enc_word;
          cnt       <= '0;
          w_valid   <= 1'b1;
          w_bit     <= enc_word[first_idx];
          w_last    <= 1'b0;
          state     <= SHIFT;
        end
        SHIFT: begin
          // Output bit, last flag and counter only move on a transfer.
          if (out_ready) begin
            if (w_last) begin
              w_valid  <= 1'b0;
              w_bit    <= 1'b0;
              w_last   <= 1'b0;
              done     <= 1'b1;
              in_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              cnt    <= cnt + NPOS_W'(1);
              w_bit  <= posit_out[next_idx];
              w_last <= ((cnt + NPOS_W'(1)) == (npos_q - NPOS_W'(1)));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_posit_serial_enc.sv
// Directed bench for fp16_posit_serial_enc: hand-computed posit words,
// serial bit order, framing, backpressure and mid-frame reset.
module tb_fp16_posit_serial_enc;

  logic        clk;
  logic        rst;
  logic        set;
  logic [3:0]  precision;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] act;
  logic        out_ready;
  logic        w_valid;
  logic        w_bit;
  logic        w_last;
  logic [7:0]  posit_out;
  logic        done;

  int n_checks = 0;
  int n_fail   = 0;

  fp16_posit_serial_enc dut (
    .clk       (clk),
    .rst       (rst),
    .set       (set),
    .precision (precision),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .act       (act),
    .out_ready (out_ready),
    .w_valid   (w_valid),
    .w_bit     (w_bit),
    .w_last    (w_last),
    .posit_out (posit_out),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One frame: hand in a word, then check every serial bit and the done pulse.
  task automatic xfer(input string tag, input logic [15:0] a, input bit do_set,
                      input logic [3:0] prec, input logic [7:0] exp_word,
                      input int n, input int stall_at, input bit mid_set);
    logic exp_b;
    @(negedge clk);
    check({tag, "_rdy"}, 16'(in_ready), 16'd1);
    in_valid  = 1'b1;
    act       = a;
    set       = do_set;
    precision = prec;
    @(negedge clk);
    in_valid = 1'b0;
    set      = 1'b0;
    check({tag, "_enc_wv"}, 16'(w_valid), 16'd0);
    for (int b = 0; b < n; b++) begin
      @(negedge clk);
      exp_b = exp_word[n-1-b];
      set   = 1'b0;
      check($sformatf("%s_v%0d", tag, b), 16'(w_valid), 16'd1);
      check($sformatf("%s_b%0d", tag, b), 16'(w_bit), 16'(exp_b));
      check($sformatf("%s_l%0d", tag, b), 16'(w_last), 16'(b == n-1));
      check($sformatf("%s_d%0d", tag, b), 16'(done), 16'd0);
      if (mid_set && b == 1) begin
        set       = 1'b1;
        precision = 4'd8;
      end
      if (b == stall_at) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          set = 1'b0;
          check($sformatf("%s_sb%0d", tag, b), 16'(w_bit), 16'(exp_b));
          check($sformatf("%s_sl%0d", tag, b), 16'(w_last), 16'(b == n-1));
          check($sformatf("%s_sr%0d", tag, b), 16'(in_ready), 16'd0);
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    set = 1'b0;
    check({tag, "_done"}, 16'(done), 16'd1);
    check({tag, "_wv_end"}, 16'(w_valid), 16'd0);
    check({tag, "_word"}, 16'(posit_out), 16'(exp_word));
  endtask

  initial begin
    rst       = 1'b0;
    set       = 1'b0;
    precision = 4'd0;
    in_valid  = 1'b0;
    act       = 16'h0000;
    out_ready = 1'b1;
    #12;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_w_valid",  16'(w_valid),  16'd0);
    check("rst_w_bit",    16'(w_bit),    16'd0);
    check("rst_w_last",   16'(w_last),   16'd0);
    check("rst_posit",    16'(posit_out), 16'd0);
    check("rst_done",     16'(done),     16'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset precision is 4: no set before the first word.
    xfer("one",    16'h3C00, 1'b0, 4'd0, 8'h4, 4, -1, 1'b0);
    xfer("m_one",  16'hBC00, 1'b0, 4'd0, 8'hC, 4, -1, 1'b0);
    xfer("one_p5", 16'h3E00, 1'b0, 4'd0, 8'h5, 4, -1, 1'b0);
    xfer("three",  16'h4200, 1'b0, 4'd0, 8'h6, 4, -1, 1'b0);
    xfer("hundred",16'h5640, 1'b0, 4'd0, 8'h7, 4, -1, 1'b0);
    xfer("tenth",  16'h2E66, 1'b0, 4'd0, 8'h1, 4, -1, 1'b0);
    xfer("nsub",   16'h8001, 1'b0, 4'd0, 8'hF, 4, -1, 1'b0);
    xfer("inf",    16'h7C00, 1'b0, 4'd0, 8'h8, 4, -1, 1'b0);
    xfer("nan",    16'h7E00, 1'b0, 4'd0, 8'h8, 4, -1, 1'b0);
    xfer("pzero",  16'h0000, 1'b0, 4'd0, 8'h0, 4, -1, 1'b0);
    xfer("nzero",  16'h8000, 1'b0, 4'd0, 8'h0, 4, -1, 1'b0);
    xfer("psub",   16'h0001, 1'b0, 4'd0, 8'h1, 4, -1, 1'b0);

    xfer("p8_three", 16'h4200, 1'b1, 4'd8,  8'h68, 8, -1, 1'b0);
    xfer("p15_1p5",  16'h3E00, 1'b1, 4'd15, 8'h50, 8, -1, 1'b0);
    xfer("p1_one",   16'h3C00, 1'b1, 4'd1,  8'h1,  2, -1, 1'b0);

    xfer("stall",    16'h3E00, 1'b1, 4'd4, 8'h5, 4, 1, 1'b0);
    xfer("midset",   16'h4200, 1'b0, 4'd0, 8'h6, 4, -1, 1'b1);
    xfer("after_ms", 16'h3C00, 1'b0, 4'd0, 8'h4, 4, -1, 1'b0);

    // Abort a frame while bit 2 of 4 is on the wire.
    @(negedge clk);
    in_valid = 1'b1;
    act      = 16'h3E00;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_wv", 16'(w_valid), 16'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 16'(in_ready), 16'd1);
    check("mid_rst_w_valid",  16'(w_valid),  16'd0);
    check("mid_rst_w_bit",    16'(w_bit),    16'd0);
    check("mid_rst_w_last",   16'(w_last),   16'd0);
    check("mid_rst_posit",    16'(posit_out), 16'd0);
    check("mid_rst_done",     16'(done),     16'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_done", 16'(done), 16'd0);
      check("post_rst_wv",   16'(w_valid), 16'd0);
    end
    xfer("post_rst", 16'h3E00, 1'b0, 4'd0, 8'h5, 4, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
